numlock_btn_arbiter: RTL and testbench

//  Conditions the raw U (BtnL) and Z (BtnR) buttons for the number-lock state machine:

---
 rtl/numlock_btn_arbiter.sv | 159 +++++++++++++++
 tb/tb_numlock_btn_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/numlock_btn_arbiter.sv
// Button conditioner for the number-lock FSM: synchronizes and debounces BtnL (U) and BtnR (Z),
// arbitrates between them and emits one tick-aligned U or Z pulse per accepted press.
module numlock_btn_arbiter #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 21
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btn_u_raw,
  input  logic       btn_z_raw,
  input  logic       tick,
  output logic       U,
  output logic       Z,
  output logic       busy,
  output logic       conflict,
  output logic [7:0] accept_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PEND_U   = 3'd1;
  localparam logic [2:0] PEND_Z   = 3'd2;
  localparam logic [2:0] DRIVE    = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries the U button, bit 1 the Z button throughout.
  logic [1:0]       raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_d;
  logic [1:0]       press;
  logic [CNT_W-1:0] deb_cnt [2];

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       u_nxt;
  logic       z_nxt;
  logic       conflict_nxt;
  logic       count_inc;

  assign raw = {btn_z_raw, btn_u_raw};

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values;
  // blocking assignments here would let sync2 see this cycle's sync1 and collapse the synchronizer.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // NOTE: the debounce counters are a tiny register array, not RAM, so resetting them is cheap
  // and keeps a press held across reset from inheriting a half-finished count.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      deb <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) deb_d <= '0;
    else       deb_d <= deb;
  end

  assign press = deb & ~deb_d;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    u_nxt        = U;
    z_nxt        = Z;
    conflict_nxt = 1'b0;
    count_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (press[0] && press[1]) begin
          conflict_nxt = 1'b1;
          state_nxt    = WAIT_REL;
        end else if (press[0]) begin
          state_nxt = PEND_U;
        end else if (press[1]) begin
          state_nxt = PEND_Z;
        end
      end
      PEND_U: begin
        if (press[1]) begin
          conflict_nxt = 1'b1;
          state_nxt    = WAIT_REL;
        end else if (tick) begin
          u_nxt     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      PEND_Z: begin
        if (press[0]) begin
          conflict_nxt = 1'b1;
          state_nxt    = WAIT_REL;
        end else if (tick) begin
          z_nxt     = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        // Held through the whole tick cycle so the FSM samples it on exactly this tick.
        if (tick) begin
          u_nxt     = 1'b0;
          z_nxt     = 1'b0;
          count_inc = 1'b1;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (deb == 2'b00) state_nxt = IDLE;
      end
      default: begin
        u_nxt     = 1'b0;
        z_nxt     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      U          <= 1'b0;
      Z          <= 1'b0;
      busy       <= 1'b0;
      conflict   <= 1'b0;
      accept_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      U        <= u_nxt;
      Z        <= z_nxt;
      busy     <= (state_nxt != IDLE);
      conflict <= conflict_nxt;
      if (count_inc) accept_cnt <= accept_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_numlock_btn_arbiter.sv
// Directed bench for numlock_btn_arbiter with short debounce and a tick every 16 cycles;
// a per-cycle monitor tallies what the lock FSM would observe.
module tb_numlock_btn_arbiter;

  localparam int DEB = 4;
  localparam int CW  = 3;

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_u_raw = 1'b0;
  logic       btn_z_raw = 1'b0;
  logic       tick      = 1'b0;
  logic       U;
  logic       Z;
  logic       busy;
  logic       conflict;
  logic [7:0] accept_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] tick_cnt = 4'd0;
  int   u_hi, z_hi, u_rise, z_rise, u_tick, z_tick, both_hi, conf_cnt;
  bit   busy_seen;
  logic u_prev, z_prev;

  numlock_btn_arbiter #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .btn_u_raw (btn_u_raw),
    .btn_z_raw (btn_z_raw),
    .tick      (tick),
    .U         (U),
    .Z         (Z),
    .busy      (busy),
    .conflict  (conflict),
    .accept_cnt(accept_cnt)
  );

  always #5 board_clk = ~board_clk;

  task automatic clear_mon();
    u_hi = 0; z_hi = 0; u_rise = 0; z_rise = 0;
    u_tick = 0; z_tick = 0; both_hi = 0; conf_cnt = 0;
    busy_seen = 1'b0; u_prev = U; z_prev = Z;
  endtask

  // Tallies the current cycle's outputs, then advances one clock; returns 1 ns after the edge.
  task automatic cycle();
    if (U === 1'b1) u_hi++;
    if (Z === 1'b1) z_hi++;
    if (U === 1'b1 && u_prev !== 1'b1) u_rise++;
    if (Z === 1'b1 && z_prev !== 1'b1) z_rise++;
    if (tick && U === 1'b1) u_tick++;
    if (tick && Z === 1'b1) z_tick++;
    if (U === 1'b1 && Z === 1'b1) both_hi++;
    if (conflict === 1'b1) conf_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
    u_prev = U;
    z_prev = Z;
    @(posedge board_clk);
    #1;
    tick_cnt = tick_cnt + 4'd1;
    tick = (tick_cnt == 4'd15);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      cycle();
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
    cycles(8);
  endtask

  task automatic test_reset();
    cycles(3);
    tests_run++;
    if ({U, Z, busy, conflict} !== 4'b0000 || accept_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: U=%b Z=%b busy=%b conflict=%b cnt=%0d, required all 0",
               U, Z, busy, conflict, accept_cnt);
    end
    reset = 1'b0;
    cycles(4);
    tests_run++;
    if ({U, Z, busy, conflict} !== 4'b0000 || accept_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: U=%b Z=%b busy=%b conflict=%b cnt=%0d, required all 0",
               U, Z, busy, conflict, accept_cnt);
    end
  endtask

  task automatic test_clean_u();
    clear_mon();
    btn_u_raw = 1'b1;
    cycles(40);
    btn_u_raw = 1'b0;
    wait_idle("clean_u");
    tests_run++;
    if (u_hi !== 16 || u_rise !== 1) begin
      tests_failed++;
      $display("FAIL clean_u_width: high=%0d rises=%0d, required 16 and 1", u_hi, u_rise);
    end
    tests_run++;
    if (u_tick !== 1 || z_hi !== 0) begin
      tests_failed++;
      $display("FAIL clean_u_ticks: u_ticks=%0d z_high=%0d, required 1 and 0", u_tick, z_hi);
    end
    tests_run++;
    if (accept_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL clean_u_count: cnt=%0d, required 1", accept_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    for (int rep = 0; rep < 3; rep++) begin
      for (int len = 1; len <= 3; len++) begin
        btn_z_raw = 1'b1;
        cycles(len);
        btn_z_raw = 1'b0;
        cycles(6);
      end
    end
    cycles(10);
    tests_run++;
    if (z_hi !== 0 || busy_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_filter: z_high=%0d busy_seen=%b, required 0 and 0", z_hi, busy_seen);
    end
    tests_run++;
    if (accept_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL glitch_count: cnt=%0d, required 1", accept_cnt);
    end
  endtask

  task automatic test_simultaneous();
    clear_mon();
    btn_u_raw = 1'b1;
    btn_z_raw = 1'b1;
    cycles(20);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_busy_held: busy=%b, required 1", busy);
    end
    btn_u_raw = 1'b0;
    btn_z_raw = 1'b0;
    wait_idle("simultaneous");
    tests_run++;
    if (conf_cnt !== 1 || u_hi !== 0 || z_hi !== 0) begin
      tests_failed++;
      $display("FAIL simul_conflict: conflict_cycles=%0d u_high=%0d z_high=%0d, required 1 0 0",
               conf_cnt, u_hi, z_hi);
    end
    tests_run++;
    if (accept_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL simul_count: cnt=%0d, required 1", accept_cnt);
    end
  endtask

  task automatic test_overlap();
    int n = 0;
    while (!tick && n < 40) begin
      cycle();
      n++;
    end
    cycle();
    clear_mon();
    // Z follows U by two cycles: both debounce well before the next tick, 15 cycles out.
    btn_u_raw = 1'b1;
    cycles(2);
    btn_z_raw = 1'b1;
    cycles(20);
    btn_u_raw = 1'b0;
    btn_z_raw = 1'b0;
    wait_idle("overlap");
    tests_run++;
    if (conf_cnt !== 1 || u_hi !== 0 || z_hi !== 0) begin
      tests_failed++;
      $display("FAIL overlap_conflict: conflict_cycles=%0d u_high=%0d z_high=%0d, required 1 0 0",
               conf_cnt, u_hi, z_hi);
    end
    tests_run++;
    if (accept_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL overlap_count: cnt=%0d, required 1", accept_cnt);
    end
  endtask

  task automatic test_reset_mid_drive();
    int n = 0;
    clear_mon();
    btn_u_raw = 1'b1;
    while (U !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    tests_run++;
    if (U !== 1'b1) begin
      tests_failed++;
      $display("FAIL drive_reached: U=%b after %0d cycles, required 1", U, n);
    end
    cycles(3);
    reset = 1'b1;
    #1;
    tests_run++;
    if (U !== 1'b0 || Z !== 1'b0 || busy !== 1'b0 || accept_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_drive: U=%b Z=%b busy=%b cnt=%0d, required 0 0 0 0",
               U, Z, busy, accept_cnt);
    end
    cycles(3);
    reset = 1'b0;
    clear_mon();
    cycles(40);
    btn_u_raw = 1'b0;
    wait_idle("reset_reaccept");
    tests_run++;
    if (u_tick !== 1 || u_hi !== 16 || z_hi !== 0) begin
      tests_failed++;
      $display("FAIL reset_reaccept: u_ticks=%0d u_high=%0d z_high=%0d, required 1 16 0",
               u_tick, u_hi, z_hi);
    end
    tests_run++;
    if (accept_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL reset_reaccept_count: cnt=%0d, required 1", accept_cnt);
    end
  endtask

  task automatic test_wrap();
    cycles(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycles(2);
    clear_mon();
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) btn_u_raw = 1'b1;
      else            btn_z_raw = 1'b1;
      cycles(8);
      btn_u_raw = 1'b0;
      btn_z_raw = 1'b0;
      wait_idle("wrap");
      if (i == 254) begin
        tests_run++;
        if (accept_cnt !== 8'd255) begin
          tests_failed++;
          $display("FAIL wrap_at_255: cnt=%0d, required 255", accept_cnt);
        end
      end
    end
    tests_run++;
    if (accept_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrap_to_zero: cnt=%0d, required 0", accept_cnt);
    end
    tests_run++;
    if (u_tick !== 128 || z_tick !== 128 || u_tick + z_tick !== 256) begin
      tests_failed++;
      $display("FAIL wrap_ticks: u_ticks=%0d z_ticks=%0d, required 128 and 128", u_tick, z_tick);
    end
    tests_run++;
    if (both_hi !== 0 || conf_cnt !== 0 || u_rise !== 128 || z_rise !== 128) begin
      tests_failed++;
      $display("FAIL wrap_exclusive: both=%0d conflicts=%0d u_rises=%0d z_rises=%0d, required 0 0 128 128",
               both_hi, conf_cnt, u_rise, z_rise);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_clean_u();
    test_glitch();
    test_simultaneous();
    test_overlap();
    test_reset_mid_drive();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
